// File: rtl/axil_ram_if.sv
// AXI4-Lite bus bundle between an initiator (master) and the axil_ram responder (slave).
interface axil_ram_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_ram.sv
// axil_ram: AXI4-Lite responder over a byte-strobed word RAM with independent write/read FSMs.
// Define AXIL_RAM_ALIGN_CHECK_EN to answer unaligned addresses with SLVERR instead of ignoring low bits.
module axil_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned MEM_WORDS  = 1024
) (
    input  logic      clk,
    input  logic      rst,
    axil_ram_if.slave s
);
    localparam int unsigned REST   = $clog2(STRB_WIDTH);
    localparam int unsigned WORD_W = ADDR_WIDTH - REST;
    localparam int unsigned MEM_AW = $clog2(MEM_WORDS);
    localparam logic [WORD_W:0] MEM_LIMIT = (WORD_W + 1)'(MEM_WORDS);

    localparam logic [1:0] W_ACCEPT = 2'd0;
    localparam logic [1:0] W_EXEC   = 2'd1;
    localparam logic [1:0] W_RESP   = 2'd2;
    localparam logic [1:0] R_IDLE   = 2'd0;
    localparam logic [1:0] R_READ   = 2'd1;
    localparam logic [1:0] R_RESP   = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [1:0]            w_state, w_state_n;
    logic                  aw_got, aw_got_n, w_got, w_got_n;
    logic [WORD_W-1:0]     aw_word, aw_word_n;
    logic                  aw_mis, aw_mis_n;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_n;
    logic                  awready_q, awready_n, wready_q, wready_n;
    logic                  bvalid_q, bvalid_n;
    logic [1:0]            bresp_q, bresp_n;

    logic [1:0]            r_state, r_state_n;
    logic [WORD_W-1:0]     ar_word, ar_word_n;
    logic                  ar_mis, ar_mis_n;
    logic                  arready_q, arready_n;
    logic                  rvalid_q, rvalid_n;
    logic [1:0]            rresp_q, rresp_n;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_n;

    logic                  aw_mis_c, ar_mis_c;
    logic [1:0]            aw_resp_c, ar_resp_c;
    logic                  mem_we_c;
    logic [DATA_WIDTH-1:0] rd_word_c;

`ifdef AXIL_RAM_ALIGN_CHECK_EN
    assign aw_mis_c = |s.awaddr[REST-1:0];
    assign ar_mis_c = |s.araddr[REST-1:0];
`else
    assign aw_mis_c = 1'b0;
    assign ar_mis_c = 1'b0;
`endif

    // Decode error wins over misalignment
    assign aw_resp_c = ({1'b0, aw_word} >= MEM_LIMIT) ? RESP_DECERR :
                       aw_mis                         ? RESP_SLVERR : RESP_OKAY;
    assign ar_resp_c = ({1'b0, ar_word} >= MEM_LIMIT) ? RESP_DECERR :
                       ar_mis                         ? RESP_SLVERR : RESP_OKAY;
    assign rd_word_c = mem[ar_word[MEM_AW-1:0]];

    assign s.awready = awready_q;
    assign s.wready  = wready_q;
    assign s.bvalid  = bvalid_q;
    assign s.bresp   = bresp_q;
    assign s.arready = arready_q;
    assign s.rvalid  = rvalid_q;
    assign s.rresp   = rresp_q;
    assign s.rdata   = rdata_q;

    // Write channel next-state: AW and W captured independently, then one execute cycle
    always_comb begin
        w_state_n = w_state;
        aw_got_n  = aw_got;
        w_got_n   = w_got;
        aw_word_n = aw_word;
        aw_mis_n  = aw_mis;
        wdata_n   = wdata_q;
        wstrb_n   = wstrb_q;
        bvalid_n  = bvalid_q;
        bresp_n   = bresp_q;
        mem_we_c  = 1'b0;
        case (w_state)
            W_ACCEPT: begin
                if (s.awvalid && awready_q) begin
                    aw_got_n  = 1'b1;
                    aw_word_n = s.awaddr[ADDR_WIDTH-1:REST];
                    aw_mis_n  = aw_mis_c;
                end
                if (s.wvalid && wready_q) begin
                    w_got_n = 1'b1;
                    wdata_n = s.wdata;
                    wstrb_n = s.wstrb;
                end
                if (aw_got_n && w_got_n) w_state_n = W_EXEC;
            end
            W_EXEC: begin
                mem_we_c  = (aw_resp_c == RESP_OKAY);
                bresp_n   = aw_resp_c;
                bvalid_n  = 1'b1;
                w_state_n = W_RESP;
            end
            W_RESP: begin
                if (s.bready) begin
                    bvalid_n  = 1'b0;
                    aw_got_n  = 1'b0;
                    w_got_n   = 1'b0;
                    w_state_n = W_ACCEPT;
                end
            end
            default: w_state_n = W_ACCEPT;
        endcase
        awready_n = (w_state_n == W_ACCEPT) && !aw_got_n;
        wready_n  = (w_state_n == W_ACCEPT) && !w_got_n;
    end

    // Read channel next-state: RAM word sampled in R_READ gives read-first collision behaviour
    always_comb begin
        r_state_n = r_state;
        ar_word_n = ar_word;
        ar_mis_n  = ar_mis;
        rvalid_n  = rvalid_q;
        rresp_n   = rresp_q;
        rdata_n   = rdata_q;
        case (r_state)
            R_IDLE: begin
                if (s.arvalid && arready_q) begin
                    ar_word_n = s.araddr[ADDR_WIDTH-1:REST];
                    ar_mis_n  = ar_mis_c;
                    r_state_n = R_READ;
                end
            end
            R_READ: begin
                rresp_n   = ar_resp_c;
                rdata_n   = (ar_resp_c == RESP_OKAY) ? rd_word_c : '0;
                rvalid_n  = 1'b1;
                r_state_n = R_RESP;
            end
            R_RESP: begin
                if (s.rready) begin
                    rvalid_n  = 1'b0;
                    r_state_n = R_IDLE;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
        arready_n = (r_state_n == R_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_ACCEPT;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_word   <= '0;
            aw_mis    <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            r_state   <= R_IDLE;
            ar_word   <= '0;
            ar_mis    <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            w_state   <= w_state_n;
            aw_got    <= aw_got_n;
            w_got     <= w_got_n;
            aw_word   <= aw_word_n;
            aw_mis    <= aw_mis_n;
            wdata_q   <= wdata_n;
            wstrb_q   <= wstrb_n;
            awready_q <= awready_n;
            wready_q  <= wready_n;
            bvalid_q  <= bvalid_n;
            bresp_q   <= bresp_n;
            r_state   <= r_state_n;
            ar_word   <= ar_word_n;
            ar_mis    <= ar_mis_n;
            arready_q <= arready_n;
            rvalid_q  <= rvalid_n;
            rresp_q   <= rresp_n;
            rdata_q   <= rdata_n;
        end
    end

    // RAM is never cleared; reset only suppresses a pending commit
    always_ff @(posedge clk) begin
        if (!rst && mem_we_c) begin
            for (int i = 0; i < int'(STRB_WIDTH); i++) begin
                if (wstrb_q[i]) mem[aw_word[MEM_AW-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axil_ram.sv
// Self-checking bench for axil_ram: directed scenarios plus random traffic against a word-array model.
module tb_axil_ram;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] ref_mem [0:1023];

    axil_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) intf ();

    axil_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_WORDS(1024)) dut (
        .clk (clk),
        .rst (rst),
        .s   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [1:0] exp_resp(input logic [15:0] a);
        if (a[15:2] >= 14'd1024) return 2'b11;
`ifdef AXIL_RAM_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) return 2'b10;
`endif
        return 2'b00;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [15:0] a);
        if (exp_resp(a) != 2'b00) return 32'h0;
        return ref_mem[a[11:2]];
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] st);
        if (exp_resp(a) == 2'b00) begin
            for (int i = 0; i < 4; i++) if (st[i]) ref_mem[a[11:2]][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    // Presents AW and W together, returns edges from handshake until bvalid is seen
    task automatic start_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] st,
                               output int lat);
        bit aw_d, w_d;
        int cyc;
        aw_d = 0; w_d = 0; cyc = 0;
        intf.awaddr = a; intf.awvalid = 1'b1;
        intf.wdata = d; intf.wstrb = st; intf.wvalid = 1'b1;
        intf.bready = 1'b0;
        while (!(aw_d && w_d) && cyc < 20) begin
            if (intf.awvalid && intf.awready) aw_d = 1;
            if (intf.wvalid && intf.wready) w_d = 1;
            @(posedge clk); #1; cyc++;
            if (aw_d) intf.awvalid = 1'b0;
            if (w_d) intf.wvalid = 1'b0;
        end
        intf.awvalid = 1'b0; intf.wvalid = 1'b0;
        lat = 0;
        while (!intf.bvalid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        model_write(a, d, st);
    endtask

    task automatic finish_b(output logic [1:0] r);
        r = intf.bresp;
        intf.bready = 1'b1;
        @(posedge clk); #1;
        intf.bready = 1'b0;
    endtask

    task automatic start_read(input logic [15:0] a, output int lat);
        bit ar_d;
        int cyc;
        ar_d = 0; cyc = 0;
        intf.araddr = a; intf.arvalid = 1'b1; intf.rready = 1'b0;
        while (!ar_d && cyc < 20) begin
            if (intf.arvalid && intf.arready) ar_d = 1;
            @(posedge clk); #1; cyc++;
        end
        intf.arvalid = 1'b0;
        lat = 0;
        while (!intf.rvalid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic finish_r(output logic [31:0] d, output logic [1:0] r);
        d = intf.rdata;
        r = intf.rresp;
        intf.rready = 1'b1;
        @(posedge clk); #1;
        intf.rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [40:0] obs;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        obs = {intf.awready, intf.wready, intf.bvalid, intf.bresp, intf.arready,
               intf.rvalid, intf.rresp, intf.rdata};
        total++;
        if (obs !== 41'h0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", obs);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({intf.awready, intf.wready, intf.arready, intf.bvalid, intf.rvalid} !== 5'b11100) begin
            bad++;
            $display("FAIL reset_release: got %b want 11100",
                     {intf.awready, intf.wready, intf.arready, intf.bvalid, intf.rvalid});
        end
    endtask

    task automatic test_fill();
        int lat;
        logic [1:0] r;
        for (int w = 0; w < 32; w++) begin
            start_write(16'(w * 4), $urandom, 4'hF, lat);
            finish_b(r);
            total++;
            if (lat !== 1 || r !== 2'b00) begin
                bad++; $display("FAIL fill_w%0d: got lat=%0d resp=%b want lat=1 resp=00", w, lat, r);
            end
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [1:0] r;
        logic [31:0] d;
        start_write(16'h0010, 32'hDEADBEEF, 4'hF, lat);
        finish_b(r);
        total++;
        if (lat !== 1 || r !== 2'b00) begin
            bad++; $display("FAIL basic_write: got lat=%0d resp=%b want lat=1 resp=00", lat, r);
        end
        start_read(16'h0010, lat);
        finish_r(d, r);
        total++;
        if (lat !== 1 || r !== 2'b00 || d !== 32'hDEADBEEF) begin
            bad++; $display("FAIL basic_read: got lat=%0d resp=%b data=%h want 1 00 deadbeef", lat, r, d);
        end
    endtask

    task automatic test_strobe_order();
        int lat;
        logic [1:0] r;
        logic [31:0] d;
        intf.wdata = 32'h11223344; intf.wstrb = 4'b0101; intf.wvalid = 1'b1;
        @(posedge clk); #1;
        intf.wvalid = 1'b0;
        total++;
        if ({intf.wready, intf.awready} !== 2'b01) begin
            bad++; $display("FAIL w_first_ready: got %b want 01", {intf.wready, intf.awready});
        end
        @(posedge clk); #1;
        intf.awaddr = 16'h0010; intf.awvalid = 1'b1;
        @(posedge clk); #1;
        intf.awvalid = 1'b0;
        total++;
        if ({intf.wready, intf.awready} !== 2'b00) begin
            bad++; $display("FAIL aw_second_ready: got %b want 00", {intf.wready, intf.awready});
        end
        lat = 0;
        while (!intf.bvalid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        model_write(16'h0010, 32'h11223344, 4'b0101);
        finish_b(r);
        total++;
        if (lat !== 1 || r !== 2'b00) begin
            bad++; $display("FAIL split_write: got lat=%0d resp=%b want lat=1 resp=00", lat, r);
        end
        start_read(16'h0010, lat);
        finish_r(d, r);
        total++;
        if (d !== 32'hDE22BE44 || d !== ref_mem[4]) begin
            bad++; $display("FAIL strobe_merge: got %h want de22be44", d);
        end
    endtask

    task automatic test_out_of_range();
        int lat;
        logic [1:0] r;
        logic [31:0] d;
        start_write(16'h1000, 32'hFFFFFFFF, 4'hF, lat);
        finish_b(r);
        total++;
        if (r !== 2'b11) begin
            bad++; $display("FAIL oor_bresp: got %b want 11", r);
        end
        start_read(16'h0000, lat);
        finish_r(d, r);
        total++;
        if (d !== ref_mem[0]) begin
            bad++; $display("FAIL oor_no_alias: got %h want %h", d, ref_mem[0]);
        end
        start_read(16'h1000, lat);
        finish_r(d, r);
        total++;
        if (d !== 32'h0 || r !== 2'b11) begin
            bad++; $display("FAIL oor_read: got data=%h resp=%b want 0 11", d, r);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [1:0] r, hr;
        logic [31:0] d, hd;
        start_write(16'h0024, 32'hCAFE0001, 4'hF, lat);
        hr = intf.bresp;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++;
            if ({intf.bvalid, intf.bresp, intf.awready, intf.wready} !== {1'b1, 2'b00, 2'b00}) begin
                bad++;
                $display("FAIL b_hold_c%0d: got %b want 10000", c,
                         {intf.bvalid, intf.bresp, intf.awready, intf.wready});
            end
        end
        finish_b(r);
        total++;
        if (r !== hr) begin
            bad++; $display("FAIL b_hold_resp: got %b want %b", r, hr);
        end
        start_read(16'h0024, lat);
        hd = intf.rdata;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++;
            if ({intf.rvalid, intf.rresp, intf.rdata, intf.arready} !== {1'b1, 2'b00, 32'hCAFE0001, 1'b0}) begin
                bad++;
                $display("FAIL r_hold_c%0d: got v=%b resp=%b data=%h arready=%b want 1 00 cafe0001 0",
                         c, intf.rvalid, intf.rresp, intf.rdata, intf.arready);
            end
        end
        finish_r(d, r);
        total++;
        if (d !== hd || d !== ref_mem[9]) begin
            bad++; $display("FAIL r_hold_data: got %h want %h", d, ref_mem[9]);
        end
    endtask

    task automatic test_collision();
        int lat;
        logic [1:0] r;
        logic [31:0] d;
        start_write(16'h0010, 32'h00000000, 4'hF, lat);
        finish_b(r);
        intf.awaddr = 16'h0010; intf.awvalid = 1'b1;
        intf.wdata = 32'hA5A5A5A5; intf.wstrb = 4'hF; intf.wvalid = 1'b1;
        intf.araddr = 16'h0010; intf.arvalid = 1'b1;
        @(posedge clk); #1;
        intf.awvalid = 1'b0; intf.wvalid = 1'b0; intf.arvalid = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({intf.bvalid, intf.rvalid, intf.rdata} !== {2'b11, 32'h0}) begin
            bad++;
            $display("FAIL collision_old: got bv=%b rv=%b data=%h want 1 1 00000000",
                     intf.bvalid, intf.rvalid, intf.rdata);
        end
        finish_b(r);
        finish_r(d, r);
        model_write(16'h0010, 32'hA5A5A5A5, 4'hF);
        start_read(16'h0010, lat);
        finish_r(d, r);
        total++;
        if (d !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL collision_new: got %h want a5a5a5a5", d);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [1:0] r;
        logic [31:0] d;
        logic [40:0] obs;
        intf.awaddr = 16'h0020; intf.awvalid = 1'b1;
        intf.wdata = 32'h12345678; intf.wstrb = 4'hF; intf.wvalid = 1'b1;
        @(posedge clk); #1;
        intf.awvalid = 1'b0; intf.wvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        obs = {intf.awready, intf.wready, intf.bvalid, intf.bresp, intf.arready,
               intf.rvalid, intf.rresp, intf.rdata};
        total++;
        if (obs !== 41'h0) begin
            bad++; $display("FAIL rst_mid_outputs: got %h want 0", obs);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({intf.awready, intf.wready, intf.arready, intf.bvalid, intf.rvalid} !== 5'b11100) begin
            bad++; $display("FAIL rst_mid_release: got %b want 11100",
                            {intf.awready, intf.wready, intf.arready, intf.bvalid, intf.rvalid});
        end
        start_read(16'h0020, lat);
        finish_r(d, r);
        total++;
        if (d !== ref_mem[8]) begin
            bad++; $display("FAIL rst_mid_no_write: got %h want %h", d, ref_mem[8]);
        end
        start_read(16'h0012, lat);
        finish_r(d, r);
        total++;
        if (r !== exp_resp(16'h0012) || d !== exp_rdata(16'h0012)) begin
            bad++; $display("FAIL low_bits_read: got resp=%b data=%h want %b %h",
                            r, d, exp_resp(16'h0012), exp_rdata(16'h0012));
        end
    endtask

    task automatic test_random();
        int lat;
        int unsigned w;
        logic [15:0] a;
        logic [31:0] d, wd;
        logic [3:0] st;
        logic [1:0] r;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) w = $urandom_range(1024, 16383);
            else w = $urandom_range(0, 31);
            a = {w[13:0], 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom;
                st = 4'($urandom_range(0, 15));
                start_write(a, wd, st, lat);
                finish_b(r);
                total++;
                if (lat !== 1 || r !== exp_resp(a)) begin
                    bad++; $display("FAIL rand_write_%0d: addr=%h got lat=%0d resp=%b want 1 %b",
                                    n, a, lat, r, exp_resp(a));
                end
            end else begin
                start_read(a, lat);
                finish_r(d, r);
                total++;
                if (lat !== 1 || r !== exp_resp(a) || d !== exp_rdata(a)) begin
                    bad++; $display("FAIL rand_read_%0d: addr=%h got lat=%0d resp=%b data=%h want 1 %b %h",
                                    n, a, lat, r, d, exp_resp(a), exp_rdata(a));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        intf.awaddr = '0; intf.awprot = 3'b000; intf.awvalid = 1'b0;
        intf.wdata = '0; intf.wstrb = '0; intf.wvalid = 1'b0; intf.bready = 1'b0;
        intf.araddr = '0; intf.arprot = 3'b000; intf.arvalid = 1'b0; intf.rready = 1'b0;
        test_reset();
        test_fill();
        test_basic();
        test_strobe_order();
        test_out_of_range();
        test_backpressure();
        test_collision();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
